// File: rtl/game24_engine_p.sv
// game24_engine_p: card-slot engine for the 24 game.
// Holds N_CARDS operand slots and merges two selected cards with an operator.
// Rejects illegal arithmetic and reports win or lose when one card is left.
// Optional build macro GAME24_UNDO_EN adds a merge history stack and the undo key (0xE).
module game24_engine_p #(
  parameter int N_CARDS = 4,
  parameter int W       = 10,
  parameter int TARGET  = 24,
  localparam int IW     = (N_CARDS > 2) ? $clog2(N_CARDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 restart,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  input  logic [N_CARDS*W-1:0] cards_in,
  output logic [N_CARDS*W-1:0] nums,
  output logic [N_CARDS-1:0]   valid_mask,
  output logic [IW-1:0]        sel_a,
  output logic [IW-1:0]        sel_b,
  output logic [1:0]           op,
  output logic [2:0]           sel_flags,
  output logic                 busy,
  output logic                 win,
  output logic                 lose,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_EXEC, S_DONE} state_t;

  state_t       state;
  logic [W-1:0] slot   [N_CARDS];
  logic [W-1:0] shadow [N_CARDS];
  logic         have_a, have_b, have_op;

  logic          card_hit, is_op, take_a, take_b, go_exec;
  logic [IW-1:0] card_idx;
  logic [1:0]    op_code;

  logic [W-1:0]       opa, opb, result;
  logic               legal, last_card;
  logic [IW-1:0]      lo, hi;
  logic [N_CARDS-1:0] merged_mask;

`ifdef GAME24_UNDO_EN
  localparam int DEPTH = N_CARDS - 1;
  localparam int SPW   = $clog2(N_CARDS) + 1;

  logic [IW-1:0]  hist_lo  [DEPTH];
  logic [IW-1:0]  hist_hi  [DEPTH];
  logic [W-1:0]   hist_lov [DEPTH];
  logic [W-1:0]   hist_hiv [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] top;
  logic           undo_hit;

  assign top      = sp - 1'b1;
  assign undo_hit = key_valid && (key_code == 4'hE) && (sp != '0) &&
                    ((state == S_SEL) || (state == S_DONE));
`endif

  assign sel_flags = {have_op, have_b, have_a};
  assign busy      = (state == S_SEL) || (state == S_EXEC);

  // Pack the slot array onto the flat output bus
  always_comb begin
    for (int i = 0; i < N_CARDS; i++) nums[i*W +: W] = slot[i];
  end

  // Decode the keypad event against the current selection
  always_comb begin
    card_hit = 1'b0;
    card_idx = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      if ((key_code == 4'(i + 1)) && valid_mask[i]) begin
        card_hit = 1'b1;
        card_idx = IW'(i);
      end
    end
    is_op   = (key_code >= 4'hA) && (key_code <= 4'hD);
    op_code = 2'(key_code - 4'hA);
    take_a  = key_valid && card_hit && !have_a;
    take_b  = key_valid && card_hit && have_a && !have_b && (card_idx != sel_a);
    go_exec = (have_a || take_a) && (have_b || take_b) && (have_op || (key_valid && is_op));
  end

  // Merge arithmetic on the two selected slots
  always_comb begin
    opa    = slot[sel_a];
    opb    = slot[sel_b];
    lo     = (sel_a < sel_b) ? sel_a : sel_b;
    hi     = (sel_a < sel_b) ? sel_b : sel_a;
    legal  = 1'b1;
    result = '0;
    case (op)
      2'd0: result = opa + opb;
      2'd1: begin
        legal  = (opa >= opb);
        result = opa - opb;
      end
      2'd2: result = opa * opb;
      default: begin
        legal  = (opb != '0) ? ((opa % opb) == '0) : 1'b0;
        result = (opb != '0) ? (opa / opb) : '0;
      end
    endcase
    merged_mask = valid_mask & ~(N_CARDS'(1) << hi);
    last_card   = ($countones(merged_mask) == 1);
  end

  // Game state machine: deal, restart, selection, merge and (optionally) undo
  always_ff @(posedge clk) begin
    err <= 1'b0;
    if (rst) begin
      state      <= S_IDLE;
      for (int i = 0; i < N_CARDS; i++) begin
        slot[i]   <= '0;
        shadow[i] <= '0;
      end
      valid_mask <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      op         <= '0;
      have_a     <= 1'b0;
      have_b     <= 1'b0;
      have_op    <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
`ifdef GAME24_UNDO_EN
      sp         <= '0;
`endif
    end else if (start) begin
      for (int i = 0; i < N_CARDS; i++) begin
        slot[i]   <= cards_in[i*W +: W];
        shadow[i] <= cards_in[i*W +: W];
      end
      valid_mask <= '1;
      have_a     <= 1'b0;
      have_b     <= 1'b0;
      have_op    <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      state      <= S_SEL;
`ifdef GAME24_UNDO_EN
      sp         <= '0;
`endif
    end else if (restart && (state != S_IDLE)) begin
      for (int i = 0; i < N_CARDS; i++) slot[i] <= shadow[i];
      valid_mask <= '1;
      have_a     <= 1'b0;
      have_b     <= 1'b0;
      have_op    <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      state      <= S_SEL;
`ifdef GAME24_UNDO_EN
      sp         <= '0;
    end else if (undo_hit) begin
      // Both slots come back; the lo slot gets its pre-merge value
      slot[hist_lo[top]]       <= hist_lov[top];
      slot[hist_hi[top]]       <= hist_hiv[top];
      valid_mask[hist_hi[top]] <= 1'b1;
      have_a                   <= 1'b0;
      have_b                   <= 1'b0;
      have_op                  <= 1'b0;
      win                      <= 1'b0;
      lose                     <= 1'b0;
      state                    <= S_SEL;
      sp                       <= top;
`endif
    end else begin
      case (state)
        S_SEL: begin
          if (key_valid) begin
            if (take_a) begin
              sel_a  <= card_idx;
              have_a <= 1'b1;
            end else if (take_b) begin
              sel_b  <= card_idx;
              have_b <= 1'b1;
            end else if (is_op) begin
              op      <= op_code;
              have_op <= 1'b1;
            end
            if (go_exec) state <= S_EXEC;
          end
        end
        S_EXEC: begin
          have_a  <= 1'b0;
          have_b  <= 1'b0;
          have_op <= 1'b0;
          if (legal) begin
            slot[lo]   <= result;
            valid_mask <= merged_mask;
`ifdef GAME24_UNDO_EN
            hist_lo[sp]  <= lo;
            hist_hi[sp]  <= hi;
            hist_lov[sp] <= slot[lo];
            hist_hiv[sp] <= slot[hi];
            sp           <= sp + 1'b1;
`endif
            // The survivor is always slot 0, which is the lo slot of the last merge
            if (last_card) begin
              state <= S_DONE;
              win   <= (result == W'(TARGET));
              lose  <= (result != W'(TARGET));
            end else begin
              state <= S_SEL;
            end
          end else begin
            err   <= 1'b1;
            state <= S_SEL;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game24_engine_p.sv
// tb_game24_engine_p: directed bench for game24_engine_p with a game-level reference model.
// Define GAME24_UNDO_EN for both files to exercise the undo history.
module tb_game24_engine_p;
  localparam int N  = 4;
  localparam int W  = 10;
  localparam int TG = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1, start = 1'b0, restart = 1'b0, key_valid = 1'b0;
  logic [3:0]     key_code = 4'd0;
  logic [N*W-1:0] cards_in = '0;
  logic [N*W-1:0] nums;
  logic [N-1:0]   valid_mask;
  logic [1:0]     sel_a, sel_b, op;
  logic [2:0]     sel_flags;
  logic           busy, win, lose, err;

  int n_checks = 0;
  int n_fail   = 0;

  game24_engine_p #(.N_CARDS(N), .W(W), .TARGET(TG)) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .key_valid(key_valid), .key_code(key_code), .cards_in(cards_in),
    .nums(nums), .valid_mask(valid_mask), .sel_a(sel_a), .sel_b(sel_b),
    .op(op), .sel_flags(sel_flags), .busy(busy), .win(win), .lose(lose), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (game-level view) ----------------
  localparam int M_IDLE = 0, M_SEL = 1, M_EXEC = 2, M_DONE = 3;
  typedef struct { int lo; int hi; int lov; int hiv; } hist_t;

  int       m_state;
  int       m_nums [N];
  int       m_hand [N];
  bit [N-1:0] m_mask;
  int       m_a, m_b, m_op;
  bit       m_fa, m_fb, m_fop, m_win, m_lose, m_err;
  hist_t    hist [$];
  bit       m_live = 1'b0;

  function automatic logic [N*W-1:0] model_pack();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_nums[i]);
    return v;
  endfunction

  task automatic model_clear_sel();
    m_fa = 0; m_fb = 0; m_fop = 0;
  endtask

  task automatic model_merge();
    int a, b, r, lo, hi;
    bit ok;
    a = m_nums[m_a];
    b = m_nums[m_b];
    ok = 1;
    r = 0;
    case (m_op)
      0: r = (a + b) % (1 << W);
      1: if (a < b) ok = 0; else r = a - b;
      2: r = (a * b) % (1 << W);
      default: if (b == 0 || (a % b) != 0) ok = 0; else r = a / b;
    endcase
    model_clear_sel();
    if (!ok) begin
      m_err = 1;
      m_state = M_SEL;
      return;
    end
    lo = (m_a < m_b) ? m_a : m_b;
    hi = (m_a < m_b) ? m_b : m_a;
    hist.push_back('{lo, hi, m_nums[lo], m_nums[hi]});
    m_nums[lo] = r;
    m_mask[hi] = 1'b0;
    if ($countones(m_mask) == 1) begin
      m_state = M_DONE;
      m_win   = (m_nums[0] == TG);
      m_lose  = !m_win;
    end else begin
      m_state = M_SEL;
    end
  endtask

  task automatic model_key(input int k);
`ifdef GAME24_UNDO_EN
    if (k == 14) begin
      if (hist.size() > 0) begin
        hist_t h;
        h = hist.pop_back();
        m_nums[h.lo] = h.lov;
        m_nums[h.hi] = h.hiv;
        m_mask[h.hi] = 1'b1;
        model_clear_sel();
        m_win = 0; m_lose = 0;
        m_state = M_SEL;
      end
      return;
    end
`endif
    if (m_state != M_SEL) return;
    if (k >= 1 && k <= N && m_mask[k-1]) begin
      if (!m_fa) begin m_a = k - 1; m_fa = 1; end
      else if (!m_fb && (k - 1) != m_a) begin m_b = k - 1; m_fb = 1; end
    end else if (k >= 10 && k <= 13) begin
      m_op = k - 10; m_fop = 1;
    end
    if (m_fa && m_fb && m_fop) m_state = M_EXEC;
  endtask

  always @(posedge clk) begin
    m_err = 0;
    if (rst) begin
      m_state = M_IDLE;
      for (int i = 0; i < N; i++) begin m_nums[i] = 0; m_hand[i] = 0; end
      m_mask = '0; m_a = 0; m_b = 0; m_op = 0;
      model_clear_sel();
      m_win = 0; m_lose = 0;
      hist.delete();
    end else if (start) begin
      for (int i = 0; i < N; i++) begin
        m_nums[i] = int'(cards_in[i*W +: W]);
        m_hand[i] = m_nums[i];
      end
      m_mask = '1; model_clear_sel(); m_win = 0; m_lose = 0;
      hist.delete();
      m_state = M_SEL;
    end else if (restart && m_state != M_IDLE) begin
      for (int i = 0; i < N; i++) m_nums[i] = m_hand[i];
      m_mask = '1; model_clear_sel(); m_win = 0; m_lose = 0;
      hist.delete();
      m_state = M_SEL;
    end else if (m_state == M_EXEC) begin
      model_merge();
    end else if (key_valid) begin
      model_key(int'(key_code));
    end
    m_live = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("nums", 64'(nums), 64'(model_pack()));
      chk("valid_mask", 64'(valid_mask), 64'(m_mask));
      chk("sel_flags", 64'(sel_flags), 64'({m_fop, m_fb, m_fa}));
      if (m_fa)  chk("sel_a", 64'(sel_a), 64'(m_a));
      if (m_fb)  chk("sel_b", 64'(sel_b), 64'(m_b));
      if (m_fop) chk("op", 64'(op), 64'(m_op));
      chk("busy", 64'(busy), 64'(m_state == M_SEL || m_state == M_EXEC));
      chk("win", 64'(win), 64'(m_win));
      chk("lose", 64'(lose), 64'(m_lose));
      chk("err", 64'(err), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] num(input int i);
    return nums[i*W +: W];
  endfunction

  task automatic tick(input logic r, input logic s, input logic rs, input logic kv, input logic [3:0] kc);
    rst = r; start = s; restart = rs; key_valid = kv; key_code = kc;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; restart = 1'b0; key_valid = 1'b0; key_code = 4'd0;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 4'd0);
  endtask

  task automatic press(input logic [3:0] k);
    tick(0, 0, 0, 1, k);
  endtask

  task automatic deal(input int c0, input int c1, input int c2, input int c3);
    cards_in = {W'(c3), W'(c2), W'(c1), W'(c0)};
    tick(0, 1, 0, 0, 4'd0);
  endtask

  task automatic keys3(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2);
    press(k0); press(k1); press(k2); idle();
  endtask

  initial begin
    tick(1, 0, 0, 0, 4'd0);
    tick(1, 0, 0, 0, 4'd0);
    chk("reset nums", 64'(nums), 64'd0);
    chk("reset mask", 64'(valid_mask), 64'd0);
    chk("reset flags", 64'(sel_flags), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    // Keys and restart in S_IDLE do nothing
    press(4'd1);
    tick(0, 0, 1, 0, 4'd0);
    chk("idle key flags", 64'(sel_flags), 64'd0);
    chk("idle restart busy", 64'(busy), 64'd0);

    // Winning sequence
    deal(1, 2, 3, 4);
    chk("deal busy", 64'(busy), 64'd1);
    keys3(4'd1, 4'hA, 4'd2);
    chk("win step1 n0", 64'(num(0)), 64'd3);
    chk("win step1 mask", 64'(valid_mask), 64'b1101);
    keys3(4'd1, 4'hA, 4'd3);
    chk("win step2 n0", 64'(num(0)), 64'd6);
    chk("win step2 mask", 64'(valid_mask), 64'b1001);
    keys3(4'd1, 4'hC, 4'd4);
    chk("win step3 n0", 64'(num(0)), 64'd24);
    chk("win step3 mask", 64'(valid_mask), 64'b0001);
    chk("win flag", 64'(win), 64'd1);
    chk("lose flag", 64'(lose), 64'd0);
    press(4'd1);
    chk("done key ignored", 64'(sel_flags), 64'd0);

`ifdef GAME24_UNDO_EN
    press(4'hE);
    chk("undo1 n0", 64'(num(0)), 64'd6);
    chk("undo1 n3", 64'(num(3)), 64'd4);
    chk("undo1 mask", 64'(valid_mask), 64'b1001);
    chk("undo1 win", 64'(win), 64'd0);
    press(4'hE);
    press(4'hE);
    chk("undo3 hand", 64'(nums), 64'({10'd4, 10'd3, 10'd2, 10'd1}));
    chk("undo3 mask", 64'(valid_mask), 64'b1111);
    press(4'hE);
    chk("undo4 mask", 64'(valid_mask), 64'b1111);
`else
    deal(1, 2, 3, 4);
    press(4'hE);
    chk("undo key ignored", 64'(sel_flags), 64'd0);
`endif

    // Illegal subtract, then legal with reversed order
    deal(2, 5, 7, 1);
    press(4'd1); press(4'hB); press(4'd2);
    idle();
    chk("sub err", 64'(err), 64'd1);
    chk("sub err n0", 64'(num(0)), 64'd2);
    chk("sub err flags", 64'(sel_flags), 64'd0);
    chk("sub err busy", 64'(busy), 64'd1);
    keys3(4'd2, 4'hB, 4'd1);
    chk("sub n0", 64'(num(0)), 64'd3);
    chk("sub mask", 64'(valid_mask), 64'b1101);

    // Division cases
    deal(7, 2, 8, 2);
    keys3(4'd1, 4'hD, 4'd2);
    chk("div rem err", 64'(err), 64'd1);
    keys3(4'd3, 4'hD, 4'd4);
    chk("div n2", 64'(num(2)), 64'd4);
    chk("div mask", 64'(valid_mask), 64'b0111);
    deal(0, 0, 5, 5);
    keys3(4'd3, 4'hD, 4'd1);
    chk("div zero err", 64'(err), 64'd1);

    // Restart after two merges
    deal(1, 2, 3, 4);
    keys3(4'd1, 4'hA, 4'd2);
    keys3(4'd1, 4'hA, 4'd3);
    tick(0, 0, 1, 0, 4'd0);
    chk("restart hand", 64'(nums), 64'({10'd4, 10'd3, 10'd2, 10'd1}));
    chk("restart mask", 64'(valid_mask), 64'b1111);

    // start beats a key in the same cycle
    cards_in = {10'd8, 10'd8, 10'd3, 10'd3};
    tick(0, 1, 0, 1, 4'd1);
    chk("start drops key", 64'(sel_flags), 64'd0);
    chk("start new hand n0", 64'(num(0)), 64'd3);

    // Ignored keys inside a selection
    press(4'd1); press(4'd1); press(4'd9); press(4'hF); press(4'hA); press(4'd3);
    idle();
    chk("ignored keys n0", 64'(num(0)), 64'd11);
    chk("ignored keys mask", 64'(valid_mask), 64'b1011);

    // Modulo add/mul wrap and a losing final value
    deal(1000, 1000, 600, 2);
    keys3(4'd1, 4'hA, 4'd2);
    chk("add wrap", 64'(num(0)), 64'd976);
    keys3(4'd3, 4'hC, 4'd4);
    chk("mul wrap", 64'(num(2)), 64'd176);
    keys3(4'd1, 4'hB, 4'd3);
    chk("lose n0", 64'(num(0)), 64'd800);
    chk("lose flag set", 64'(lose), 64'd1);

    // Reset in the middle of S_EXEC
    deal(1, 2, 3, 4);
    press(4'd1); press(4'hC); press(4'd2);
    tick(1, 0, 0, 0, 4'd0);
    chk("exec rst nums", 64'(nums), 64'd0);
    chk("exec rst mask", 64'(valid_mask), 64'd0);
    chk("exec rst sel", 64'({sel_a, sel_b, op, sel_flags}), 64'd0);
    chk("exec rst status", 64'({busy, win, lose, err}), 64'd0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
